// File: rtl/mono_data_tx_pkg.sv
// Shared definitions for the Monopix end-of-column readout: hit field widths,
// serial word width and serialiser state encodings. Also used on the receive side.
package mono_data_tx_pkg;

  localparam int COL_W   = 6;
  localparam int ROW_W   = 8;
  localparam int LE_W    = 6;
  localparam int TE_W    = 6;
  localparam int WORD_W  = COL_W + ROW_W + LE_W + TE_W;  // 26, MSB sent first
  localparam int BITCNT_W = 5;                           // counts 25..0

  typedef logic [WORD_W-1:0] hit_word_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_WAIT  = 2'd1,
    SER_SHIFT = 2'd2
  } ser_state_e;

endpackage

// File: rtl/mono_data_tx_if.sv
// Hit injection and token/serial readout signals of the transmitter.
// slave: the transmitter itself; master: whoever injects hits and reads them.
interface mono_data_tx_if;
  import mono_data_tx_pkg::*;

  logic             HIT_WR;
  logic [COL_W-1:0] HIT_COL;
  logic [ROW_W-1:0] HIT_ROW;
  logic [LE_W-1:0]  HIT_LE;
  logic [TE_W-1:0]  HIT_TE;
  logic             HIT_FULL;
  logic             FREEZE;
  logic             READ;
  logic             TOKEN;
  logic             DATA;
  logic             DATA_VALID;
  logic [7:0]       LOST_CNT;
  logic             READ_ERR;

  modport slave (
    input  HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, FREEZE, READ,
    output HIT_FULL, TOKEN, DATA, DATA_VALID, LOST_CNT, READ_ERR
  );

  modport master (
    output HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, FREEZE, READ,
    input  HIT_FULL, TOKEN, DATA, DATA_VALID, LOST_CNT, READ_ERR
  );

endinterface

// File: rtl/mono_data_tx_hit_fifo.sv
// Hit FIFO with first-word-fall-through head, occupancy count and full/empty.
// A push while full is accepted only together with a pop on the same edge.
module mono_tx_hit_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 26,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; an empty FIFO never exposes stale entries.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mono_data_tx.sv
// Monopix end-of-column transmitter: buffers hits, raises TOKEN while hits are
// pending, honours the FREEZE snapshot and serialises one 26-bit word per READ edge.
module mono_data_tx
  import mono_data_tx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int DATA_LATENCY = 2
) (
  input logic           CLK,
  input logic           nRST,
  mono_data_tx_if.slave bus
);

  localparam int       CW        = $clog2(DEPTH) + 1;
  localparam bit [2:0] WAIT_INIT = 3'(DATA_LATENCY - 1);

  // FIFO side
  hit_word_t       fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, pop, drop;

  // Control decodes
  logic            read_acc, freeze_rise, pending, ser_busy;

  // Registered state
  logic            read_q, freeze_q;
  logic [CW-1:0]   frozen_cnt_q, frozen_cnt_d;
  ser_state_e      state_q, state_d;
  logic [2:0]      wait_cnt_q, wait_cnt_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  hit_word_t       shift_q, shift_d;
  logic            data_q, data_d;
  logic            valid_q, valid_d;
  logic            token_q, token_d;
  logic            full_q;
  logic [7:0]      lost_q, lost_d;
  logic            err_q, err_d;

  mono_tx_hit_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.HIT_COL, bus.HIT_ROW, bus.HIT_LE, bus.HIT_TE}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The last SHIFT cycle (bit_cnt 0) already counts as idle so back-to-back
  // words are possible DATA_LATENCY+26 edges apart.
  assign read_acc    = bus.READ && !read_q;
  assign freeze_rise = bus.FREEZE && !freeze_q;
  assign pending     = freeze_q ? (frozen_cnt_q != '0) : !fifo_empty;
  assign ser_busy    = (state_q == SER_WAIT) || ((state_q == SER_SHIFT) && (bit_cnt_q != '0));
  assign pop         = read_acc && !ser_busy && pending;
  assign drop        = bus.HIT_WR && fifo_full && !pop;
  assign push        = bus.HIT_WR && !drop;

  // Serialiser, freeze snapshot and status next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = 1'b0;
    valid_d    = 1'b0;

    unique case (state_q)
      SER_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d   = SER_SHIFT;
          data_d    = shift_q[WORD_W-1];
          valid_d   = 1'b1;
          shift_d   = {shift_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = BITCNT_W'(WORD_W - 1);
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      SER_SHIFT: begin
        if (bit_cnt_q != '0) begin
          data_d    = shift_q[WORD_W-1];
          valid_d   = 1'b1;
          shift_d   = {shift_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BITCNT_W'(1);
        end else begin
          state_d = SER_IDLE;
        end
      end
      default: ;
    endcase

    if (pop) begin
      state_d    = SER_WAIT;
      shift_d    = fifo_rdata;
      wait_cnt_d = WAIT_INIT;
      data_d     = 1'b0;
      valid_d    = 1'b0;
    end

    // Snapshot taken against occupancy before this edge's write.
    if (!bus.FREEZE)     frozen_cnt_d = '0;
    else if (freeze_rise) frozen_cnt_d = fifo_count - CW'(pop);
    else                 frozen_cnt_d = frozen_cnt_q - CW'(pop);

    token_d = freeze_q ? (frozen_cnt_q != '0) : !fifo_empty;
    lost_d  = (drop && (lost_q != 8'hFF)) ? lost_q + 8'd1 : lost_q;
    err_d   = err_q | (read_acc && !pop);
  end

  // All control state and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      read_q       <= 1'b0;
      freeze_q     <= 1'b0;
      frozen_cnt_q <= '0;
      state_q      <= SER_IDLE;
      wait_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= 1'b0;
      valid_q      <= 1'b0;
      token_q      <= 1'b0;
      full_q       <= 1'b0;
      lost_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      read_q       <= bus.READ;
      freeze_q     <= bus.FREEZE;
      frozen_cnt_q <= frozen_cnt_d;
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      token_q      <= token_d;
      full_q       <= fifo_full;
      lost_q       <= lost_d;
      err_q        <= err_d;
    end
  end

  assign bus.TOKEN      = token_q;
  assign bus.DATA       = data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.HIT_FULL   = full_q;
  assign bus.LOST_CNT   = lost_q;
  assign bus.READ_ERR   = err_q;

endmodule

// File: tb/tb_mono_data_tx.sv
// Directed bench for mono_data_tx (DEPTH 16, DATA_LATENCY 2). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mono_data_tx;
  import mono_data_tx_pkg::*;

  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mono_data_tx_if bus();

  mono_data_tx #(.DEPTH(16), .DATA_LATENCY(LAT)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic hit_word_t mk(input int col, input int row, input int le, input int te);
    return {6'(col), 8'(row), 6'(le), 6'(te)};
  endfunction

  task automatic write_hit(input hit_word_t w);
    bus.HIT_COL = w[25:20];
    bus.HIT_ROW = w[19:12];
    bus.HIT_LE  = w[11:6];
    bus.HIT_TE  = w[5:0];
    bus.HIT_WR  = 1'b1;
    tick();
    bus.HIT_WR  = 1'b0;
  endtask

  // Pulses READ (accept edge k), then gathers the serial word. first = i where
  // the first bit showed after edge k+i; err_at > 0 pulses READ again at edge k+err_at.
  task automatic read_hit(input int err_at, output hit_word_t w, output int nv,
                          output int first, output logic tok_k1);
    w = '0; nv = 0; first = -1; tok_k1 = 1'bx;
    bus.READ = 1'b1;
    tick();
    bus.READ   = 1'b0;
    bus.HIT_WR = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      bus.READ = (i == err_at);
      tick();
      if (i == 1) tok_k1 = bus.TOKEN;
      if (bus.DATA_VALID) begin
        if (first < 0) first = i;
        w = {w[24:0], bus.DATA};
        nv++;
      end else if (nv > 0) begin
        break;
      end
    end
    bus.READ = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hit_word_t w, h, x;
    hit_word_t f[5];
    hit_word_t o[20];
    int nv, first;
    logic tk;

    bus.HIT_WR = 0; bus.HIT_COL = 0; bus.HIT_ROW = 0; bus.HIT_LE = 0; bus.HIT_TE = 0;
    bus.FREEZE = 0; bus.READ = 0;

    // ---- reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_token",    32'(bus.TOKEN),      32'd0);
    check("rst_data",     32'(bus.DATA),       32'd0);
    check("rst_valid",    32'(bus.DATA_VALID), 32'd0);
    check("rst_full",     32'(bus.HIT_FULL),   32'd0);
    check("rst_lost",     32'(bus.LOST_CNT),   32'd0);
    check("rst_err",      32'(bus.READ_ERR),   32'd0);

    // ---- single hit: COL=5 ROW=100 LE=3 TE=9 -> 26'h05640C9
    h = mk(5, 100, 3, 9);
    write_hit(h);
    check("single_token_k",  32'(bus.TOKEN), 32'd0);
    tick();
    check("single_token_k1", 32'(bus.TOKEN), 32'd1);
    read_hit(0, w, nv, first, tk);
    check("single_word",     32'(w),     32'h05640C9);
    check("single_nbits",    32'(nv),    32'd26);
    check("single_latency",  32'(first), 32'(LAT));
    check("single_token_rd", 32'(tk),    32'd0);
    check("single_data_end", 32'(bus.DATA), 32'd0);

    // ---- freeze snapshot
    for (int i = 0; i < 5; i++) f[i] = mk(10 + i, 200 - i, i, 60 - i);
    write_hit(f[0]); write_hit(f[1]); write_hit(f[2]);
    bus.FREEZE = 1'b1;
    tick();
    write_hit(f[3]); write_hit(f[4]);
    tick();
    check("frz_token_on", 32'(bus.TOKEN), 32'd1);
    read_hit(0, w, nv, first, tk);
    check("frz_word0", 32'(w), 32'(f[0]));
    check("frz_tok0",  32'(tk), 32'd1);
    read_hit(0, w, nv, first, tk);
    check("frz_word1", 32'(w), 32'(f[1]));
    read_hit(0, w, nv, first, tk);
    check("frz_word2", 32'(w), 32'(f[2]));
    check("frz_tok2",  32'(tk), 32'd0);
    check("frz_token_held_low", 32'(bus.TOKEN), 32'd0);
    bus.FREEZE = 1'b0;
    tick();
    tick();
    check("unfrz_token", 32'(bus.TOKEN), 32'd1);
    read_hit(0, w, nv, first, tk);
    check("unfrz_word3", 32'(w), 32'(f[3]));
    read_hit(0, w, nv, first, tk);
    check("unfrz_word4", 32'(w), 32'(f[4]));
    check("unfrz_tok4",  32'(tk), 32'd0);

    // ---- overflow: 20 writes into a 16-deep FIFO
    for (int i = 0; i < 20; i++) o[i] = mk(i, i * 7 + 1, i + 3, 63 - i);
    for (int i = 0; i < 20; i++) write_hit(o[i]);
    tick();
    check("ovf_full", 32'(bus.HIT_FULL), 32'd1);
    check("ovf_lost", 32'(bus.LOST_CNT), 32'd4);

    // ---- full FIFO, push and pop on the same edge
    x = mk(33, 77, 21, 12);
    bus.HIT_COL = x[25:20]; bus.HIT_ROW = x[19:12]; bus.HIT_LE = x[11:6]; bus.HIT_TE = x[5:0];
    bus.HIT_WR = 1'b1;
    read_hit(0, w, nv, first, tk);
    check("pp_word0", 32'(w), 32'(o[0]));
    check("pp_lost",  32'(bus.LOST_CNT), 32'd4);
    check("pp_full",  32'(bus.HIT_FULL), 32'd1);
    for (int i = 1; i < 16; i++) begin
      read_hit(0, w, nv, first, tk);
      check($sformatf("ovf_word%0d", i), 32'(w), 32'(o[i]));
    end
    read_hit(0, w, nv, first, tk);
    check("pp_word_new", 32'(w), 32'(x));
    check("drain_full",  32'(bus.HIT_FULL), 32'd0);
    check("drain_token", 32'(bus.TOKEN),    32'd0);
    check("drain_err",   32'(bus.READ_ERR), 32'd0);

    // ---- READ re-asserted 5 cycles into a shift
    h = mk(1, 2, 3, 4);
    x = mk(62, 255, 0, 63);
    write_hit(h); write_hit(x);
    read_hit(LAT + 5, w, nv, first, tk);
    check("busy_word",  32'(w),  32'(h));
    check("busy_nbits", 32'(nv), 32'd26);
    check("busy_err",   32'(bus.READ_ERR), 32'd1);
    check("busy_token", 32'(bus.TOKEN), 32'd1);
    read_hit(0, w, nv, first, tk);
    check("busy_no_pop", 32'(w), 32'(x));

    // ---- reset 10 cycles into a shift
    h = mk(7, 8, 9, 10);
    write_hit(h);
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    repeat (LAT + 9) tick();
    check("mid_valid", 32'(bus.DATA_VALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data",  32'(bus.DATA),       32'd0);
    check("arst_valid", 32'(bus.DATA_VALID), 32'd0);
    check("arst_token", 32'(bus.TOKEN),      32'd0);
    check("arst_full",  32'(bus.HIT_FULL),   32'd0);
    check("arst_lost",  32'(bus.LOST_CNT),   32'd0);
    check("arst_err",   32'(bus.READ_ERR),   32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    x = mk(44, 123, 55, 6);
    write_hit(x);
    tick();
    read_hit(0, w, nv, first, tk);
    check("post_rst_word",    32'(w),     32'(x));
    check("post_rst_nbits",   32'(nv),    32'd26);
    check("post_rst_latency", 32'(first), 32'(LAT));

    // ---- READ with nothing pending
    read_hit(0, w, nv, first, tk);
    check("empty_nbits", 32'(nv), 32'd0);
    check("empty_err",   32'(bus.READ_ERR), 32'd1);
    check("empty_data",  32'(bus.DATA), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
